// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, realigns the one-cycle registered
// instruction-memory read data with its PC, and holds output across decode stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_instruction,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  // Handshake: decode raises stall when it cannot accept; while stall is high
  // the presented instruction/PC stay fixed. Redirect overrides stall.

  logic [31:0] pc_q, pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] hold_q, hold_d;
  logic        holding_q, holding_d;

  always_comb begin
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rsp_valid_q;
    hold_d      = hold_q;
    holding_d   = holding_q;
    if (redirect) begin
      // The word arriving next cycle belongs to the squashed path.
      pc_d        = {redirect_target[31:2], 2'b00};
      rsp_valid_d = 1'b0;
      holding_d   = 1'b0;
    end else if (stall) begin
      // Capture only on the first stall cycle; later reads re-fetch pc_q.
      if (!holding_q) begin
        hold_d    = mem_instruction;
        holding_d = 1'b1;
      end
    end else begin
      rsp_pc_d    = pc_q;
      rsp_valid_d = 1'b1;
      pc_d        = pc_q + 32'd4;
      holding_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      hold_q      <= 32'h0;
      holding_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
      hold_q      <= hold_d;
      holding_q   <= holding_d;
    end
  end

  assign mem_pc         = pc_q;
  assign id_pc          = rsp_pc_q;
  assign id_pc_plus4    = rsp_pc_q + 32'd4;
  assign id_valid       = rsp_valid_q;
  assign id_instruction = !rsp_valid_q ? 32'h0 : (holding_q ? hold_q : mem_instruction);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and 0xFFFFFFF8)
// each backed by a registered instruction-memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_target;
  logic [31:0] mem_pc, mem_rdata, id_instruction, id_pc, id_pc_plus4;
  logic        id_valid;
  logic [31:0] w_mem_pc, w_mem_rdata, w_id_instruction, w_id_pc, w_id_pc_plus4;
  logic        w_id_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .mem_pc(mem_pc), .mem_instruction(mem_rdata),
    .id_valid(id_valid), .id_instruction(id_instruction), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .mem_pc(w_mem_pc), .mem_instruction(w_mem_rdata),
    .id_valid(w_id_valid), .id_instruction(w_id_instruction), .id_pc(w_id_pc),
    .id_pc_plus4(w_id_pc_plus4)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h1111_1111;
      32'h4:   mem_word = 32'h2222_2222;
      32'h8:   mem_word = 32'h3333_3333;
      default: mem_word = {16'hA5A5, a[15:0]};
    endcase
  endfunction

  always @(posedge clock) begin
    mem_rdata   <= mem_word(mem_pc);
    w_mem_rdata <= mem_word(w_mem_pc);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (mem_pc !== 32'h0) begin n_err++; $display("FAIL reset_mem_pc got %h exp %h", mem_pc, 32'h0); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", id_valid); end
    n_cmp++; if (id_instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", id_instruction); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
    n_cmp++; if (id_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc_plus4 got %h exp 4", id_pc_plus4); end
    n_cmp++; if (w_mem_pc !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL reset_wrap_mem_pc got %h exp fffffff8", w_mem_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h1111_1111; exp_w[1] = 32'h2222_2222; exp_w[2] = 32'h3333_3333;
    do_reset();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL stream_cycle0_valid got %b exp 0", id_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b exp 1", k, id_valid); end
      n_cmp++; if (id_pc !== 32'(4 * k)) begin n_err++; $display("FAIL stream_pc[%0d] got %h exp %h", k, id_pc, 32'(4 * k)); end
      n_cmp++; if (id_instruction !== exp_w[k]) begin n_err++; $display("FAIL stream_instr[%0d] got %h exp %h", k, id_instruction, exp_w[k]); end
      n_cmp++; if (id_pc_plus4 !== 32'(4 * k + 4)) begin n_err++; $display("FAIL stream_plus4[%0d] got %h exp %h", k, id_pc_plus4, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) stall = 1'b0;
      n_cmp++; if (id_pc !== 32'h4) begin n_err++; $display("FAIL stall_pc[%0d] got %h exp 4", k, id_pc); end
      n_cmp++; if (id_instruction !== 32'h2222_2222) begin n_err++; $display("FAIL stall_instr[%0d] got %h exp 22222222", k, id_instruction); end
      n_cmp++; if (mem_pc !== 32'h8) begin n_err++; $display("FAIL stall_mem_pc[%0d] got %h exp 8", k, mem_pc); end
      if (k < 3) tick();
    end
    tick();
    n_cmp++; if (id_pc !== 32'h8) begin n_err++; $display("FAIL stall_release_pc got %h exp 8", id_pc); end
    n_cmp++; if (id_instruction !== 32'h3333_3333) begin n_err++; $display("FAIL stall_release_instr got %h exp 33333333", id_instruction); end
    tick();
    n_cmp++; if (id_pc !== 32'hC) begin n_err++; $display("FAIL stall_after_pc got %h exp c", id_pc); end
    n_cmp++; if (id_instruction !== 32'hA5A5_000C) begin n_err++; $display("FAIL stall_after_instr got %h exp a5a5000c", id_instruction); end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_target = 32'h0000_0103;
    n_cmp++; if (id_pc !== 32'h8) begin n_err++; $display("FAIL redir_cycle_pc got %h exp 8", id_pc); end
    tick();
    redirect = 1'b0;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble_valid got %b exp 0", id_valid); end
    n_cmp++; if (id_instruction !== 32'h0) begin n_err++; $display("FAIL redir_bubble_instr got %h exp 0", id_instruction); end
    n_cmp++; if (mem_pc !== 32'h100) begin n_err++; $display("FAIL redir_mem_pc0 got %h exp 100", mem_pc); end
    tick();
    n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL redir_target_valid got %b exp 1", id_valid); end
    n_cmp++; if (id_pc !== 32'h100) begin n_err++; $display("FAIL redir_target_pc got %h exp 100", id_pc); end
    n_cmp++; if (id_instruction !== 32'hA5A5_0100) begin n_err++; $display("FAIL redir_target_instr got %h exp a5a50100", id_instruction); end
    n_cmp++; if (mem_pc !== 32'h104) begin n_err++; $display("FAIL redir_mem_pc1 got %h exp 104", mem_pc); end
  endtask

  task automatic test_redirect_during_stall();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    tick();
    redirect = 1'b1; redirect_target = 32'h0000_0200;
    tick();
    redirect = 1'b0; stall = 1'b0;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rds_bubble_valid got %b exp 0", id_valid); end
    n_cmp++; if (id_instruction !== 32'h0) begin n_err++; $display("FAIL rds_bubble_instr got %h exp 0", id_instruction); end
    n_cmp++; if (mem_pc !== 32'h200) begin n_err++; $display("FAIL rds_mem_pc got %h exp 200", mem_pc); end
    tick();
    stall = 1'b1;
    n_cmp++; if (id_pc !== 32'h200) begin n_err++; $display("FAIL rds_pc got %h exp 200", id_pc); end
    n_cmp++; if (id_instruction !== 32'hA5A5_0200) begin n_err++; $display("FAIL rds_instr got %h exp a5a50200", id_instruction); end
    tick();
    stall = 1'b0;
    n_cmp++; if (id_pc !== 32'h200) begin n_err++; $display("FAIL rds_hold_pc got %h exp 200", id_pc); end
    n_cmp++; if (id_instruction !== 32'hA5A5_0200) begin n_err++; $display("FAIL rds_hold_instr got %h exp a5a50200", id_instruction); end
    tick();
    n_cmp++; if (id_pc !== 32'h204) begin n_err++; $display("FAIL rds_next_pc got %h exp 204", id_pc); end
    n_cmp++; if (id_instruction !== 32'hA5A5_0204) begin n_err++; $display("FAIL rds_next_instr got %h exp a5a50204", id_instruction); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    n_cmp++; if (w_id_pc !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_pc0 got %h exp fffffff8", w_id_pc); end
    n_cmp++; if (w_id_instruction !== 32'hA5A5_FFF8) begin n_err++; $display("FAIL wrap_instr0 got %h exp a5a5fff8", w_id_instruction); end
    tick();
    n_cmp++; if (w_id_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc1 got %h exp fffffffc", w_id_pc); end
    n_cmp++; if (w_id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4 got %h exp 0", w_id_pc_plus4); end
    n_cmp++; if (w_mem_pc !== 32'h0) begin n_err++; $display("FAIL wrap_mem_pc got %h exp 0", w_mem_pc); end
    tick();
    n_cmp++; if (w_id_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc2 got %h exp 0", w_id_pc); end
    n_cmp++; if (w_id_instruction !== 32'h1111_1111) begin n_err++; $display("FAIL wrap_instr2 got %h exp 11111111", w_id_instruction); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rms_valid got %b exp 0", id_valid); end
    n_cmp++; if (id_instruction !== 32'h0) begin n_err++; $display("FAIL rms_instr got %h exp 0", id_instruction); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL rms_pc got %h exp 0", id_pc); end
    n_cmp++; if (id_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rms_plus4 got %h exp 4", id_pc_plus4); end
    n_cmp++; if (mem_pc !== 32'h0) begin n_err++; $display("FAIL rms_mem_pc got %h exp 0", mem_pc); end
    reset = 1'b0;
    tick();
    stall = 1'b0;
    n_cmp++; if (id_instruction !== 32'h0) begin n_err++; $display("FAIL rms_bubble_instr got %h exp 0", id_instruction); end
    tick();
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL rms_resume_pc got %h exp 0", id_pc); end
    n_cmp++; if (id_instruction !== 32'h1111_1111) begin n_err++; $display("FAIL rms_resume_instr got %h exp 11111111", id_instruction); end
    tick();
    n_cmp++; if (id_pc !== 32'h4) begin n_err++; $display("FAIL rms_next_pc got %h exp 4", id_pc); end
    n_cmp++; if (id_instruction !== 32'h2222_2222) begin n_err++; $display("FAIL rms_next_instr got %h exp 22222222", id_instruction); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_during_stall();
    test_wrap();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS pipeline. Owns the program counter, drives the fetch address into the byte-addressed instruction memory, and realigns that memory's one-cycle registered read data with the PC that produced it. Presents a valid-tagged instruction, its PC, and PC+4 to the decode stage. Supports decode-stage stalls (with a hold buffer) and branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  decode cannot accept; hold current output.
- redirect  in  1  branch/jump resolved taken this cycle.
- redirect_target  in  32  new fetch address; bits [1:0] ignored (treated as 00).
- mem_pc  out  32  address to instruction memory, equal to pc_reg.
- mem_instruction  in  32  instruction memory read data; valid one cycle after mem_pc is sampled.
- id_valid  out  1  decode-stage outputs carry a real instruction.
- id_instruction  out  32  instruction to decode; 32'h0 (NOP) when id_valid=0.
- id_pc  out  32  address of id_instruction.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.

## Operation
- State: pc_reg (next fetch address), rsp_pc, rsp_valid (tag of the word now on mem_instruction), hold_reg[31:0], holding.
- Outputs are combinational from state:
  - id_pc = rsp_pc.
  - id_pc_plus4 = rsp_pc + 4.
  - id_valid = rsp_valid.
  - id_instruction = !rsp_valid ? 0 : (holding ? hold_reg : mem_instruction).
- Per-edge priority: reset > redirect > stall > sequential.
- Reset:
  - pc_reg=RESET_PC; rsp_pc=0; rsp_valid=0; holding=0; hold_reg=0.
  - Output reset values: mem_pc=RESET_PC, id_valid=0, id_instruction=0, id_pc=0, id_pc_plus4=32'h4.
- Redirect:
  - pc_reg <= {redirect_target[31:2],2'b00}; rsp_valid <= 0; holding <= 0.
  - The word fetched on this edge is squashed.
  - The output in the redirect cycle is not killed; decode owns it.
- Stall, no redirect:
  - pc_reg, rsp_pc and rsp_valid hold.
  - If holding=0: hold_reg <= mem_instruction and holding <= 1.
  - If holding=1: hold_reg holds.
  - The memory keeps re-reading pc_reg; that data is ignored while holding.
- Sequential:
  - rsp_pc <= pc_reg; rsp_valid <= 1; pc_reg <= pc_reg + 4; holding <= 0.
- PC arithmetic: 32-bit unsigned, wraps 32'hFFFF_FFFC -> 32'h0000_0000, no error flag.

## Timing
- Fetch latency: an address on mem_pc in cycle N produces id_valid=1 for that address in cycle N+1, absent stall or redirect.
- First valid output: cycle 1 after reset deasserts (cycle 0 output is invalid).
- Throughput: one instruction per cycle when stall=0.
- Redirect penalty: exactly one bubble.
  - Cycle N: redirect asserted.
  - Cycle N+1: id_valid=0.
  - Cycle N+2: id_pc = target.
- Stall: the output in the first stall cycle comes from mem_instruction. Later stall cycles and the release cycle come from hold_reg. id_pc is unchanged across the whole stall.
- Stall release: the cycle after the release edge presents the word at the held pc_reg. No instruction is dropped or duplicated.
- Stall with id_valid=0: holds the bubble; id_instruction stays 0.
- Redirect and stall together: redirect wins; holding is cleared.
- Reset mid-stall or mid-redirect: reset values appear the cycle after the reset edge; fetch restarts at RESET_PC.

## Test plan
- **Reset and stream.** RESET_PC=0; memory words 0x11111111, 0x22222222, 0x33333333 at 0, 4, 8; deassert reset -> cycle 0 id_valid=0. Cycles 1, 2, 3 give id_pc = 0, 4, 8 with those words and id_pc_plus4 = 4, 8, 12.
- **Three-cycle stall.** Assert stall while id_pc=4 -> id_pc stays 4, id_instruction stays 0x22222222, mem_pc stays 8. After release the next id_pc is 8 (0x33333333), then 12; no skip or repeat.
- **Misaligned redirect.** Redirect to 0x103 while id_pc=8 -> next cycle id_valid=0 and id_instruction=0. Following cycle id_pc=0x100; mem_pc sequence is 0x100, 0x104.
- **Redirect during stall.** Assert redirect to 0x200 during the second stall cycle -> holding cleared, one bubble, then id_pc=0x200, even with stall still high one more cycle after the bubble.
- **Wrap-around.** RESET_PC=0xFFFFFFF8 -> id_pc = 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. id_pc_plus4 for 0xFFFFFFFC is 0x00000000.
- **Reset mid-stall.** Assert reset during a stall -> next cycle all outputs at reset values, holding=0. After release, fetch resumes at RESET_PC.
